bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Burst read sequencer for the read port of the simple dual-port BRAM (1-cycle registered read).
//  On start it sweeps `length` words from `base_addr`, drives enb/addrb and captures dob.
//  Read data goes out as a valid/ready stream with no loss under backpressure.
//  Feeds LSTM weight/state words from BRAM to the downstream MAC datapath.
// PARAMETERS
//  WIDTH       32   data word width; matches the BRAM WIDTH
//  DEPTH       256  BRAM depth in words; ADDR_WIDTH = $clog2(DEPTH) (localparam)
//  FIFO_DEPTH  3    output buffer entries; minimum 3, for full throughput without a ready->enb combinational path
// PORTS
//  clk        in   1              clock; single clock domain
//  rst_n      in   1              asynchronous active-low reset
//  start      in   1              begin burst; sampled only in IDLE
//  base_addr  in   ADDR_WIDTH     first word address; sampled with start
//  length     in   ADDR_WIDTH+1   word count, 0..DEPTH; sampled with start
//  busy       out  1              high from the cycle after start is accepted until the done cycle (inclusive)
//  done       out  1              one-cycle pulse on burst completion
//  enb        out  1              BRAM read enable
//  addrb      out  ADDR_WIDTH     BRAM read address
//  dob        in   WIDTH          BRAM read data; valid the cycle after enb
//  m_data     out  WIDTH          stream data = FIFO head
//  m_valid    out  1              stream valid
//  m_ready    in   1              stream ready; a transfer happens when m_valid && m_ready
// BEHAVIOUR
//  Reset values: all outputs are 0; FSM = IDLE; FIFO is empty; the in-flight flag is cleared.
//  Reset mid-burst: the burst is abandoned; no done pulse; the buffered data is discarded.
//  FSM states: IDLE, ISSUE, DRAIN.
//   IDLE  -> ISSUE  on start with length != 0.
//   IDLE  -> IDLE   on start with length == 0; done pulses the next cycle; busy stays 0; no reads.
//   ISSUE -> DRAIN  after the last read is issued.
//   DRAIN -> IDLE   when the final word transfers on m_*; done pulses in that same cycle.
//  start while busy: ignored; base_addr and length are not resampled.
//  Read issue rule (ISSUE state only): enb = 1 iff remaining != 0 and (fifo_count + inflight) < FIFO_DEPTH.
//  Per read: addrb = current address. Address increments modulo DEPTH, wrapping from DEPTH-1 to 0.
//  inflight is set by enb and cleared the next cycle. That cycle, dob is pushed into the FIFO.
//  The credit rule guarantees a push never finds the FIFO full. Push and pop in the same cycle are both allowed.
//  Latency, with start sampled at edge N:
//   cycle N+1: enb = 1, addrb = base.
//   edge N+2:  dob is captured into the FIFO.
//   cycle N+3: m_valid = 1.
//  Throughput: 1 word/cycle while m_ready = 1.
//  Backpressure: m_data and m_valid stay stable until the transfer; enb stalls once credit is exhausted.
//  length == DEPTH: every address is read once, starting at base and wrapping.
//  Words emitted = length exactly, in address order.
// CONFIGURATION
//  Macro BRAM_STREAM_READER_LAST_EN.
//  Defined: adds output m_last (1 bit), stored per FIFO entry. m_last is high with the final word of the burst and 0 at reset.
//  Undefined: no m_last port and no extra FIFO bit; behaviour is otherwise identical.
// STRUCTURE
//  Package lstm_mem_pkg holds:
//   - the reader_state_t enum {IDLE, ISSUE, DRAIN};
//   - the localparam MIN_READ_FIFO_DEPTH = 3;
//   - the BRAM_READ_LATENCY = 1 constant.
//  Sub-module bram_read_fifo:
//   - a FIFO_DEPTH x WIDTH(+1) register FIFO;
//   - push/pop/count interface;
//   - asynchronous active-low reset;
//   - head is exposed combinationally.
//  Top level holds the FSM, the address/remaining counters, the credit logic and the done/busy generation.
// TESTING
//  1. base=0x10, length=4, m_ready=1 held:
//     -> enb high in cycles N+1..N+4 with addrb 0x10..0x13;
//     -> m_valid in N+3..N+6 with data ram[0x10..0x13];
//     -> done in N+6.
//  2. base=0xFE, length=4, DEPTH=256 -> addrb sequence 0xFE, 0xFF, 0x00, 0x01; four words out in that order.
//  3. length=8 with m_ready low for 10 cycles, then high:
//     -> enb stops after 3 reads;
//     -> m_data is held stable while stalled;
//     -> all 8 words arrive in order with none lost or duplicated;
//     -> done coincides with the 8th transfer.
//  4. length=0 -> no enb; done pulses once the cycle after start; m_valid never rises.
//  5. Second start pulse mid-burst -> ignored; the burst completes unchanged and done pulses once.
//  6. rst_n asserted mid-burst (asynchronously):
//     -> all outputs are 0 immediately;
//     -> after release, a new burst base=0x20, length=2 streams ram[0x20..0x21] correctly.
//  With BRAM_STREAM_READER_LAST_EN defined: m_last is high only on the final word of scenarios 1 and 3.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// lstm_mem_pkg: shared types and constants for the LSTM memory read path.
package lstm_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} reader_state_t;
    localparam int MIN_READ_FIFO_DEPTH = 3;
    localparam int BRAM_READ_LATENCY = 1;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: control, BRAM read port and output stream of the reader.
// m_last exists only when BRAM_STREAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [WIDTH-1:0]      dob;
    logic [WIDTH-1:0]      m_data;
    logic                  m_valid;
    logic                  m_ready;
`ifdef BRAM_STREAM_READER_LAST_EN
    logic                  m_last;
`endif
    modport master (
        input  start, base_addr, length, dob, m_ready,
`ifdef BRAM_STREAM_READER_LAST_EN
        output m_last,
`endif
        output busy, done, enb, addrb, m_data, m_valid
    );
    modport slave (
        output start, base_addr, length, dob, m_ready,
`ifdef BRAM_STREAM_READER_LAST_EN
        input  m_last,
`endif
        input  busy, done, enb, addrb, m_data, m_valid
    );
endinterface

// File: rtl/bram_read_fifo.sv
// bram_read_fifo: small register FIFO with a combinational head; push into a full FIFO
// must be prevented by the caller.
module bram_read_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                din,
    input  logic                         pop,
    output logic [DW-1:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: burst reader for a 1-cycle BRAM read port, streaming words out over valid/ready.
// Define BRAM_STREAM_READER_LAST_EN to add m_last on the final word of each burst.
module bram_stream_reader
    import lstm_mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    bram_stream_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FD = (FIFO_DEPTH < MIN_READ_FIFO_DEPTH) ? MIN_READ_FIFO_DEPTH : FIFO_DEPTH;
    localparam int CW = $clog2(FD + 1);
`ifdef BRAM_STREAM_READER_LAST_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif
    reader_state_t state;
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          zero_done;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic [DW-1:0] head;
    logic [DW-1:0] din;
    logic          pop;
    logic          last_xfer;
    // Words in the FIFO plus the one still coming out of the BRAM must never exceed its depth.
    assign credit_used  = {1'b0, count} + (CW + 1)'(inflight);
    assign bus.enb      = state == ISSUE && remaining != '0 && credit_used < (CW + 1)'(FD);
    assign bus.addrb    = addr;
    assign bus.m_valid  = count != '0;
    assign pop          = bus.m_valid && bus.m_ready;
    assign last_xfer    = state == DRAIN && !inflight && count == CW'(1) && pop;
    assign bus.done     = last_xfer || zero_done;
    assign bus.busy     = state != IDLE;
    assign bus.m_data   = head[WIDTH-1:0];
`ifdef BRAM_STREAM_READER_LAST_EN
    logic inflight_last;
    assign din        = {inflight_last, bus.dob};
    assign bus.m_last = head[WIDTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_last <= 1'b0;
        else inflight_last <= bus.enb && remaining == (AW + 1)'(1);
    end
`else
    assign din = bus.dob;
`endif
    bram_read_fifo #(.DW(DW), .DEPTH(FD)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            inflight  <= bus.enb;
            zero_done <= state == IDLE && bus.start && bus.length == '0;
            case (state)
                IDLE: if (bus.start && bus.length != '0) begin
                    state     <= ISSUE;
                    addr      <= bus.base_addr;
                    remaining <= bus.length;
                end
                ISSUE: if (bus.enb) begin
                    addr      <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == (AW + 1)'(1)) state <= DRAIN;
                end
                DRAIN: if (last_xfer) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: table-driven and randomized bursts checked against an address/word-list model.
module tb_bram_stream_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_stream_reader_if #(.WIDTH(32), .DEPTH(256)) bus ();
    bram_stream_reader #(.WIDTH(32), .DEPTH(256), .FIFO_DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram [256];
    always @(posedge clk) if (bus.enb) bus.dob <= ram[bus.addrb];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int stall, input int k);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return k > stall;
        return 1'b1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_enb"}, bus.enb, 0);
        chk({tag, "_addrb"}, bus.addrb, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_valid"}, bus.m_valid, 0);
        chk({tag, "_data"}, bus.m_data, 0);
`ifdef BRAM_STREAM_READER_LAST_EN
        chk({tag, "_last"}, bus.m_last, 0);
`endif
    endtask

    // Expected behaviour: reads cover (base+i)%256 in order, words come out in the same order,
    // at most 3 words are outstanding, and done marks the final transfer (or k=1 for length 0).
    task automatic run_burst(input int base, input int len, input int mode, input int stall,
                             input int restart, input int e_enb, input int e_valid, input int e_done);
        int addr_q[$];
        logic [31:0] exp_q[$];
        int k = 0, first_enb = 0, first_valid = 0, done_k = 0, issued = 0, xfers = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic xfer, last;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back((base + i) % 256);
            exp_q.push_back(ram[(base + i) % 256]);
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = 8'(base);
        bus.length = 9'(len);
        bus.m_ready = ready_for(mode, stall, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.base_addr = 8'($urandom);
        bus.length = 9'($urandom_range(1, 256));
        while (done_k == 0 && k < 600) begin
            k++;
            @(negedge clk);
            chk("busy", bus.busy, len != 0);
            if (bus.enb) begin
                issued++;
                if (first_enb == 0) first_enb = k;
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("addrb", bus.addrb, addr_q.pop_front());
                chk("credit", (issued - xfers) <= 3, 1);
            end
            if (bus.m_valid) begin
                if (first_valid == 0) first_valid = k;
                if (prev_stall) chk("stable_data", bus.m_data, prev_data);
            end else if (prev_stall) chk("stable_valid", bus.m_valid, 1);
            xfer = bus.m_valid && bus.m_ready;
            last = 1'b0;
            if (xfer) begin
                xfers++;
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    chk("m_data", bus.m_data, exp_q.pop_front());
                    last = exp_q.size() == 0;
`ifdef BRAM_STREAM_READER_LAST_EN
                    chk("m_last", bus.m_last, last);
`endif
                end
            end
            chk("done", bus.done, last || (len == 0 && k == 1));
            if (bus.done) done_k = k;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            @(posedge clk); #1;
            bus.m_ready = ready_for(mode, stall, k + 1);
            bus.start = (k + 1 == restart);
            bus.base_addr = 8'($urandom);
            bus.length = 9'($urandom_range(1, 256));
        end
        bus.start = 1'b0;
        bus.m_ready = 1'b1;
        if (done_k == 0) chk("timeout_done", 0, 1);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        if (e_enb >= 0) chk("first_enb_cycle", first_enb, e_enb);
        if (e_valid >= 0) chk("first_valid_cycle", first_valid, e_valid);
        if (e_done >= 0) chk("done_cycle", done_k, e_done);
        @(negedge clk);
        chk("busy_after", bus.busy, 0);
        chk("done_once", bus.done, 0);
        chk("valid_after", bus.m_valid, 0);
    endtask

    typedef struct {
        int base, len, mode, stall, restart, e_enb, e_valid, e_done;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{'h10, 4,   0, 0,  0, 1, 3, 6};
        vecs[1] = '{'hFE, 4,   0, 0,  0, 1, 3, 6};
        vecs[2] = '{'h40, 8,   2, 10, 0, 1, 3, 18};
        vecs[3] = '{'h33, 0,   0, 0,  0, 0, 0, 1};
        vecs[4] = '{'h50, 5,   0, 0,  2, 1, 3, 7};
        vecs[5] = '{'h80, 256, 0, 0,  0, 1, 3, 258};
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        foreach (vecs[i])
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].stall,
                      vecs[i].restart, vecs[i].e_enb, vecs[i].e_valid, vecs[i].e_done);
        for (int r = 0; r < 12; r++)
            run_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 24)), 1, 0, 0, -1, -1, -1);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = 8'h60;
        bus.length = 9'd10;
        bus.m_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        run_burst('h20, 2, 0, 0, 0, 1, 3, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
